// File: rtl/addsub_pkg.sv
// Shared types and helpers for the add/sub issue stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package addsub_pkg;

  // Operand width of the attached ripple-carry adder and its sign-bit index.
  localparam int ADDSUB_W   = 8;
  localparam int ADDSUB_MSB = ADDSUB_W - 1;

  // One queued add/sub command.
  typedef struct packed {
    logic [ADDSUB_W-1:0] a;
    logic [ADDSUB_W-1:0] b;
    logic                sub;
    logic                acc_sel;
  } cmd_t;

  // Controller view: EXEC issues this cycle, STALL holds the FIFO head behind a
  // full result slot, HOLD is a full slot with nothing queued behind it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_STALL = 2'd2,
    ST_HOLD  = 2'd3
  } ctrl_state_e;

  // Signed two's-complement overflow from operand and result sign bits.
  // Subtract overflows when operand signs differ and the result sign leaves A's.
  function automatic logic calc_ovf(
    input logic [ADDSUB_W-1:0] a,
    input logic [ADDSUB_W-1:0] b,
    input logic [ADDSUB_W-1:0] sum,
    input logic                sub
  );
    logic same_sign;
    logic sign_flip;
    same_sign = (a[ADDSUB_MSB] == b[ADDSUB_MSB]);
    sign_flip = (sum[ADDSUB_MSB] != a[ADDSUB_MSB]);
    calc_ovf  = (sub ? !same_sign : same_sign) && sign_flip;
  endfunction

endpackage

// File: rtl/addsub_cmd_fifo.sv
// DEPTH-entry synchronous FIFO of add/sub commands; head is read combinationally.
// Latency: an entry pushed at edge N is visible at o_head after edge N (no bypass).
// Backpressure: pushes ignored while full, pops ignored while empty.
module addsub_cmd_fifo
  import addsub_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  cmd_t i_dat,
  output cmd_t o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  cmd_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/addsub_issue_unit.sv
// Queues add/sub commands, issues one per cycle to the external adder, registers the result + flags.
// Latency: push at edge N issues in cycle N+1 (empty queue), result valid after edge N+1.
// Backpressure: out_ready low holds the slot and the FIFO head; in_ready drops only when the FIFO is full.
module addsub_issue_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  output logic             add_en,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc
);

  cmd_t              w_push_cmd;
  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_issue;
  ctrl_state_e       w_state;
  logic              w_out_valid_nxt;

  logic              w_carry;
  logic              w_borrow;
  logic              w_zero;
  logic              w_ovf;

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_result;
  logic              r_out_carry;
  logic              r_out_borrow;
  logic              r_out_zero;
  logic              r_out_ovf;
  logic [WIDTH-1:0]  r_acc;

  // Command intake: in_ready is a pure function of occupancy, never of out_ready.
  assign in_ready   = ~w_full;
  assign w_push     = in_valid & ~w_full;
  assign w_push_cmd = '{a: in_a, b: in_b, sub: in_sub, acc_sel: in_acc};

  addsub_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_dat   (w_push_cmd),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Controller decode: the slot's valid bit is the state register, combined with FIFO occupancy.
  always_comb begin
    w_state = ST_IDLE;
    if (!w_empty && (!r_out_valid || out_ready)) begin
      w_state = ST_EXEC;
    end else if (!w_empty) begin
      w_state = ST_STALL;
    end else if (r_out_valid) begin
      w_state = ST_HOLD;
    end
  end

  assign w_issue = (w_state == ST_EXEC);

  // Next slot-valid per state: EXEC refills, HOLD drains on out_ready, STALL and IDLE keep it.
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    case (w_state)
      ST_EXEC:  w_out_valid_nxt = 1'b1;
      ST_HOLD:  w_out_valid_nxt = ~out_ready;
      ST_STALL: w_out_valid_nxt = 1'b1;
      ST_IDLE:  w_out_valid_nxt = 1'b0;
      default:  w_out_valid_nxt = r_out_valid;
    endcase
  end

  // Adder drive from the FIFO head, zeroed whenever nothing issues.
  always_comb begin
    add_en  = w_issue;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (w_issue) begin
      add_a   = w_head.acc_sel ? r_acc : w_head.a;
      add_b   = w_head.b;
      add_sub = w_head.sub;
    end
  end

  // Status flags; borrow is computed here because the adder masks carry on subtract.
  always_comb begin
    w_carry  = add_cout & ~add_sub;
    w_borrow = add_sub & (add_a < add_b);
    w_zero   = (add_sum == '0);
    w_ovf    = calc_ovf(add_a, add_b, add_sum, add_sub);
  end

  // Result slot: load on issue, otherwise hold data and let valid follow the controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_carry  <= 1'b0;
      r_out_borrow <= 1'b0;
      r_out_zero   <= 1'b0;
      r_out_ovf    <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_issue) begin
        r_out_result <= add_sum;
        r_out_carry  <= w_carry;
        r_out_borrow <= w_borrow;
        r_out_zero   <= w_zero;
        r_out_ovf    <= w_ovf;
      end
    end
  end

  // Accumulator tracks every issued result; a clear wins over the same-edge update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_issue) begin
      r_acc <= add_sum;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_carry  = r_out_carry;
  assign out_borrow = r_out_borrow;
  assign out_zero   = r_out_zero;
  assign out_ovf    = r_out_ovf;
  assign acc        = r_acc;

endmodule

// File: tb/tb_addsub_issue_unit.sv
// Bench for addsub_issue_unit with a behavioural ripple adder and an in-order result scoreboard.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_addsub_issue_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_sub;
  logic       in_acc;
  logic       acc_clr;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_sub;
  logic       add_en;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_borrow;
  logic       out_zero;
  logic       out_ovf;
  logic [7:0] acc;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [11:0] exp_q[$];
  int          pop_cyc[$];
  logic [7:0]  m_acc   = 8'h00;

  addsub_issue_unit #(.WIDTH(8), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_acc     (in_acc),
    .acc_clr    (acc_clr),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sub    (add_sub),
    .add_en     (add_en),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_ovf    (out_ovf),
    .acc        (acc)
  );

  // Behavioural adder: carry forced to 0 on subtract.
  logic [8:0] add_wide;
  assign add_wide = add_sub ? {1'b0, add_a - add_b} : ({1'b0, add_a} + {1'b0, add_b});
  assign add_sum  = add_wide[7:0];
  assign add_cout = add_sub ? 1'b0 : add_wide[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {ovf, zero, borrow, carry, result} from integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    int         sa;
    int         sb;
    int         sr;
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    logic       bw;
    logic       o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      w  = {1'b0, a} + {1'b0, b};
      r  = w[7:0];
      c  = w[8];
      bw = 1'b0;
      sr = sa + sb;
    end else begin
      r  = a - b;
      c  = 1'b0;
      bw = (a < b);
      sr = sa - sb;
    end
    o = (sr > 127) || (sr < -128);
    return {o, (r == 8'h00), bw, c, r};
  endfunction

  // Drive one command; expected value is queued in issue order.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic accsel);
    logic [11:0] e;
    int          t;
    e = model(accsel ? m_acc : a, b, sub);
    exp_q.push_back(e);
    m_acc    = e[7:0];
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_acc   = accsel;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("push_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Result monitor: every accepted result is compared against the queue head.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        chk("result", {24'd0, out_result}, {24'd0, e[7:0]});
        chk("flags", {28'd0, out_ovf, out_zero, out_borrow, out_carry}, {28'd0, e[11:8]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    logic [7:0]  held;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_acc", {24'd0, acc}, 32'd0);
    chk("rst_add_en", {31'd0, add_en}, 32'd0);
    chk("rst_result", {24'd0, out_result}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Single add with latency check.
    push(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_add_en", {31'd0, add_en}, 32'd1);
    chk("lat_add_a", {24'd0, add_a}, 32'h7F);
    chk("lat_no_valid_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // Subtracts with borrow and overflow.
    push(8'h05, 8'h07, 1'b1, 1'b0);
    push(8'h80, 8'h01, 1'b1, 1'b0);
    wait_drain();

    // Accumulate from zero, back to back.
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = 8'h00;
    chk("clr_acc", {24'd0, acc}, 32'd0);
    n0 = pop_cyc.size();
    for (int i = 0; i < 3; i++) push(8'hAA, 8'h10, 1'b0, 1'b1);
    wait_drain();
    chk("accum_acc", {24'd0, acc}, 32'h30);
    chk("accum_gap1", pop_cyc[n0+1] - pop_cyc[n0], 1);
    chk("accum_gap2", pop_cyc[n0+2] - pop_cyc[n0+1], 1);

    // acc_clr during an in_acc issue.
    push(8'h00, 8'h05, 1'b0, 1'b1);
    acc_clr = 1'b1;
    @(negedge clk);
    chk("clr_issue_a", {24'd0, add_a}, 32'h30);
    @(posedge clk); #1;
    acc_clr = 1'b0;
    m_acc = 8'h00;
    chk("clr_after", {24'd0, acc}, 32'd0);
    wait_drain();

    // Backpressure: slot plus two FIFO entries, then drain in order.
    out_ready = 1'b0;
    push(8'h01, 8'h02, 1'b0, 1'b0);
    push(8'hF0, 8'h20, 1'b0, 1'b0);
    push(8'h10, 8'h30, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_add_en", {31'd0, add_en}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    held = out_result;
    chk("bp_first", {24'd0, held}, 32'h03);
    repeat (3) @(negedge clk);
    chk("bp_stable", {24'd0, out_result}, {24'd0, held});
    @(posedge clk); #1;
    n0 = pop_cyc.size();
    out_ready = 1'b1;
    wait_drain();
    chk("bp_gap1", pop_cyc[n0+1] - pop_cyc[n0], 1);
    chk("bp_gap2", pop_cyc[n0+2] - pop_cyc[n0+1], 1);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

    // Reset with a full FIFO and a held result.
    out_ready = 1'b0;
    push(8'h11, 8'h22, 1'b0, 1'b0);
    push(8'h33, 8'h44, 1'b0, 1'b0);
    push(8'h55, 8'h66, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_acc = 8'h00;
    @(negedge clk);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_acc", {24'd0, acc}, 32'd0);
    chk("mrst_add_en", {31'd0, add_en}, 32'd0);

    // Post-reset sanity: carry out with a zero result.
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(8'h0F, 8'hF1, 1'b0, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
